// File: rtl/seqdet_pkg.sv
// Shared state encoding, constants and helpers for the seqdet arbitration controller.
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Pattern the latched configuration holds out of reset
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/seqdet_prog.sv
// Programmable Mealy sequence detector: shifts one bit per enabled cycle and
// counts pattern matches, overlapping or not.
module seqdet_prog #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match_pulse,
  output logic [CNT_W-1:0] count
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_reg, hist_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;

  generate
    if (PAT_W == 1) begin : g_hist_one
      assign hist_shift = bit_in;
    end else begin : g_hist_many
      assign hist_shift = {hist_reg[PAT_W-2:0], bit_in};
    end
  endgenerate

  // Fill saturates so a full window stays full while overlapping
  assign fill_inc = (fill_reg == FILL_W'(PAT_W)) ? fill_reg : fill_reg + FILL_W'(1);

  always_comb begin
    hist_next   = hist_reg;
    fill_next   = fill_reg;
    count_next  = count_reg;
    match_pulse = 1'b0;
    if (clr) begin
      hist_next  = '0;
      fill_next  = '0;
      count_next = '0;
    end else if (bit_en) begin
      hist_next = hist_shift;
      fill_next = fill_inc;
      if (fill_inc == FILL_W'(PAT_W) && hist_shift == pattern) begin
        match_pulse = 1'b1;
        count_next  = count_reg + CNT_W'(1);
        if (!overlap) begin
          fill_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      count_reg <= '0;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seqdet_arb_ctrl.sv
// Round-robin scheduler sharing one seqdet_prog detector among N_REQ requesters.
// Defining SEQDET_FIRST_POS_EN adds the resp_first_pos and resp_found outputs.
module seqdet_arb_ctrl
  import seqdet_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = $clog2(WORD_W) + 1,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int POS_W  = $clog2(WORD_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [PAT_W-1:0]        cfg_pattern,
  input  logic                    cfg_overlap,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [CNT_W-1:0]        resp_count,
  output logic                    busy
`ifdef SEQDET_FIRST_POS_EN
  ,
  output logic [POS_W-1:0]        resp_first_pos,
  output logic                    resp_found
`endif
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [PAT_W-1:0]  pat_reg, pat_next;
  logic              ovl_reg, ovl_next;
  logic [POS_W-1:0]  bit_cnt_reg, bit_cnt_next;

  logic [WORD_W-1:0] req_word [N_REQ];
  logic              grant_found;
  logic [ID_W-1:0]   grant_id, cand_id;
  logic [N_REQ-1:0]  grant_onehot;

  logic              det_clr, det_en, det_match;
  logic [CNT_W-1:0]  det_count;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_word[gi]     = req_data[gi*WORD_W +: WORD_W];
      assign grant_onehot[gi] = grant_found && (grant_id == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_id = ID_W'((int'(ptr_reg) + k) % N_REQ);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    id_next      = id_reg;
    word_next    = word_reg;
    pat_next     = pat_reg;
    ovl_next     = ovl_reg;
    bit_cnt_next = bit_cnt_reg;
    det_clr      = 1'b0;
    det_en       = 1'b0;
    req_ready    = '0;
    case (state_reg)
      IDLE: begin
        req_ready = grant_onehot;
        if (grant_found) begin
          word_next    = req_word[grant_id];
          id_next      = grant_id;
          pat_next     = cfg_pattern;
          ovl_next     = cfg_overlap;
          bit_cnt_next = '0;
          det_clr      = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        det_en       = 1'b1;
        word_next    = {word_reg[WORD_W-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + POS_W'(1);
        if (bit_cnt_reg == POS_W'(WORD_W - 1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          ptr_next   = ID_W'(wrap_inc(int'(id_reg), N_REQ));
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      id_reg      <= '0;
      word_reg    <= '0;
      pat_reg     <= PAT_W'(DEFAULT_PATTERN);
      ovl_reg     <= 1'b0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      word_reg    <= word_next;
      pat_reg     <= pat_next;
      ovl_reg     <= ovl_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Word shifts left each SHIFT cycle, so the MSB is always the bit under test
  seqdet_prog #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_det (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (det_clr),
    .bit_en      (det_en),
    .bit_in      (word_reg[WORD_W-1]),
    .pattern     (pat_reg),
    .overlap     (ovl_reg),
    .match_pulse (det_match),
    .count       (det_count)
  );

  assign resp_valid = (state_reg == RESP);
  assign resp_id    = id_reg;
  assign resp_count = det_count;
  assign busy       = (state_reg != IDLE);

`ifdef SEQDET_FIRST_POS_EN
  logic [POS_W-1:0] first_pos_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pos_reg <= '0;
    end else if (det_clr) begin
      first_pos_reg <= '0;
    end else if (det_en && det_match && det_count == '0) begin
      first_pos_reg <= bit_cnt_reg;
    end
  end

  assign resp_first_pos = first_pos_reg;
  assign resp_found     = (det_count != '0);
`else
  logic unused_match;
  assign unused_match = det_match;
`endif

endmodule

// File: tb/tb_seqdet_arb_ctrl.sv
// Directed bench for seqdet_arb_ctrl with a window-scanning reference model.
module tb_seqdet_arb_ctrl;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;
  localparam int ID_W   = 2;
  localparam int POS_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*WORD_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [PAT_W-1:0]        cfg_pattern = 4'b1010;
  logic                    cfg_overlap = 1'b0;
  logic                    resp_valid;
  logic                    resp_ready = 1'b1;
  logic [ID_W-1:0]         resp_id;
  logic [CNT_W-1:0]        resp_count;
  logic                    busy;
`ifdef SEQDET_FIRST_POS_EN
  logic [POS_W-1:0]        resp_first_pos;
  logic                    resp_found;
`endif

  seqdet_arb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_count  (resp_count),
    .busy        (busy)
`ifdef SEQDET_FIRST_POS_EN
    ,
    .resp_first_pos (resp_first_pos),
    .resp_found     (resp_found)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scan every window of the word, MSB first; non-overlapping matches must start after the previous one ended
  function automatic int model_count(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                                     input logic ovl, output int first);
    int cnt;
    int last_end;
    bit hit;
    cnt = 0;
    last_end = -1;
    first = 0;
    for (int e = PAT_W - 1; e < WORD_W; e++) begin
      int s;
      s = e - PAT_W + 1;
      hit = 1'b1;
      for (int j = 0; j < PAT_W; j++) begin
        if (w[WORD_W-1-(s+j)] != p[PAT_W-1-j]) hit = 1'b0;
      end
      if (hit && (ovl || s > last_end)) begin
        cnt++;
        if (cnt == 1) first = e;
        last_end = e;
      end
    end
    return cnt;
  endfunction

  function automatic int model_arb(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  // Model state and DUT observation log
  bit m_busy = 1'b0;
  int m_ptr = 0, m_age = 0, m_id = 0, m_cnt = 0, m_first = 0;
  int cyc = 0, grant_cyc = 0, last_latency = 0, last_id = -1, last_cnt = -1, n_resp = 0;
  bit rv_prev = 1'b0;
  int grants[$];

  initial begin
    bit exp_rv;
    int w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_ptr  = 0;
        m_age  = 0;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_count", int'(resp_count), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef SEQDET_FIRST_POS_EN
        chk("rst_first_pos", int'(resp_first_pos), 0);
        chk("rst_found", int'(resp_found), 0);
`endif
      end else begin
        if (m_busy) m_age++;
        exp_rv = m_busy && (m_age >= WORD_W + 1);
        w = m_busy ? -1 : model_arb(req_valid, m_ptr);
        chk("req_ready", int'(req_ready), (w >= 0) ? (1 << w) : 0);
        chk("busy", int'(busy), m_busy ? 1 : 0);
        chk("resp_valid", int'(resp_valid), exp_rv ? 1 : 0);
        if (exp_rv) begin
          chk("resp_id", int'(resp_id), m_id);
          chk("resp_count", int'(resp_count), m_cnt);
`ifdef SEQDET_FIRST_POS_EN
          chk("resp_first_pos", int'(resp_first_pos), m_first);
          chk("resp_found", int'(resp_found), (m_cnt > 0) ? 1 : 0);
`endif
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (req_ready[i]) begin
            grants.push_back(i);
            grant_cyc = cyc;
          end
        end
        if (resp_valid && !rv_prev) last_latency = cyc - grant_cyc;
        if (resp_valid && resp_ready) begin
          last_id  = int'(resp_id);
          last_cnt = int'(resp_count);
          n_resp++;
          $display("resp id=%0d count=%0d cycle=%0d", resp_id, resp_count, cyc);
        end
        if (!m_busy) begin
          if (w >= 0) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = w;
            m_cnt  = model_count(req_data[w*WORD_W +: WORD_W], cfg_pattern, cfg_overlap, m_first);
          end
        end else if (exp_rv && resp_ready) begin
          m_busy = 1'b0;
          m_ptr  = (m_id + 1) % N_REQ;
        end
      end
      rv_prev = resp_valid;
    end
  end

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!req_ready[i] && n < 60);
    chk("grant_timeout", int'(req_ready[i]), 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [WORD_W-1:0] w);
    @(posedge clk); #1;
    req_data[i*WORD_W +: WORD_W] = w;
    req_valid[i] = 1'b1;
    wait_grant(i);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (busy && n < 60);
    chk("done_timeout", int'(busy), 0);
  endtask

  task automatic job(input int i, input logic [WORD_W-1:0] w);
    send(i, w);
    wait_done();
  endtask

  task automatic grant_all(input int n);
    int base, k;
    base = grants.size();
    @(posedge clk); #1;
    req_valid = '1;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (grants.size() < base + n && k < 200);
    chk("grant_all_timeout", grants.size() - base, n);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin
    int r, f, base, nr;
    // Hand-computed values pinning the reference model
    r = model_count(16'hAAAA, 4'b1010, 1'b0, f); chk("model_aaaa_nov", r, 4); chk("model_aaaa_first", f, 3);
    r = model_count(16'hAAAA, 4'b1010, 1'b1, f); chk("model_aaaa_ov", r, 7);
    r = model_count(16'hFFFF, 4'b1111, 1'b1, f); chk("model_ffff_ov", r, 13);
    r = model_count(16'hFFFF, 4'b1111, 1'b0, f); chk("model_ffff_nov", r, 4);
    r = model_count(16'h0000, 4'b1111, 1'b1, f); chk("model_zero", r, 0);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_resp_valid", int'(resp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_resp_count", int'(resp_count), 0);

    // Basic counts and latency
    cfg_pattern = 4'b1010; cfg_overlap = 1'b0;
    job(0, 16'hAAAA);
    chk("aaaa_nov_id", last_id, 0);
    chk("aaaa_nov_count", last_cnt, 4);
    chk("latency", last_latency, 17);
    cfg_overlap = 1'b1;
    job(0, 16'hAAAA);
    chk("aaaa_ov_count", last_cnt, 7);
    cfg_pattern = 4'b1111;
    job(1, 16'hFFFF);
    chk("ffff_ov_count", last_cnt, 13);
    chk("ffff_ov_id", last_id, 1);
    cfg_overlap = 1'b0;
    job(2, 16'hFFFF);
    chk("ffff_nov_count", last_cnt, 4);
    job(3, 16'h0000);
    chk("zero_count", last_cnt, 0);

    // Round-robin with every requester asserting, pointer starts at 0
    cfg_pattern = 4'b1010; cfg_overlap = 1'b1;
    req_data = {16'h0F0F, 16'hF0F0, 16'hA5A5, 16'h1234};
    base = grants.size();
    grant_all(5);
    wait_done();
    if (grants.size() >= base + 5) begin
      chk("rr_g0", grants[base], 0);
      chk("rr_g1", grants[base+1], 1);
      chk("rr_g2", grants[base+2], 2);
      chk("rr_g3", grants[base+3], 3);
      chk("rr_g4", grants[base+4], 0);
    end

    // Lone requester 2 with pointer 0, then pointer must be 3
    job(3, 16'h5555);
    job(2, 16'hAAAA);
    chk("solo_grant", grants[grants.size()-1], 2);
    grant_all(1);
    wait_done();
    chk("ptr_after_2", grants[grants.size()-1], 3);

    // Back-pressure in RESP
    cfg_pattern = 4'b1010; cfg_overlap = 1'b0;
    resp_ready = 1'b0;
    send(1, 16'hAAAA);
    nr = 0;
    do begin
      @(negedge clk); #1;
      nr++;
    end while (!resp_valid && nr < 40);
    chk("hold_rv_timeout", int'(resp_valid), 1);
    @(posedge clk); #1;
    req_data[0 +: WORD_W] = 16'h1234;
    req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_id", int'(resp_id), 1);
      chk("hold_count", int'(resp_count), 4);
      chk("hold_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_grant(0);
    wait_done();

    // Config changes after grant do not affect the job in flight
    cfg_pattern = 4'b1010; cfg_overlap = 1'b0;
    send(1, 16'hAAAA);
    cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    wait_done();
    chk("cfg_latched_count", last_cnt, 4);
    cfg_pattern = 4'b1010; cfg_overlap = 1'b0;

    // Reset at bit 8 of SHIFT drops the job
    send(2, 16'hFFFF);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    nr = n_resp;
    @(negedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_resp_valid", int'(resp_valid), 0);
    chk("midrst_resp_count", int'(resp_count), 0);
    chk("midrst_resp_id", int'(resp_id), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    chk("midrst_no_resp", n_resp - nr, 0);
    req_data[0 +: WORD_W] = 16'hAAAA;
    grant_all(1);
    wait_done();
    chk("post_rst_grant", grants[grants.size()-1], 0);
    chk("post_rst_id", last_id, 0);
    chk("post_rst_count", last_cnt, 4);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
